// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding select, load-use / scoreboard stall
// detection, a per-register multi-cycle busy scoreboard and stall statistics.
//
// Handshake note: this block has no valid/ready pairs. src_vld qualifies each
// source operand in the same cycle, and mc_issue is a single-cycle strobe that
// the block always accepts. stall and fwd_sel are combinational and valid in
// the same cycle as their inputs. Registered state (busy_vec, stall_cnt,
// stall_max) changes only on the rising clock edge, except for the
// asynchronous reset.
module hazard_forward_unit #(
  parameter int AW      = 3,
  parameter int NSRC    = 2,
  parameter int LATW    = 3,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*AW-1:0]   src_ID_RF,
  input  logic [NSRC-1:0]      src_vld,
  input  logic [AW-1:0]        dest_RF_EX,
  input  logic [AW-1:0]        dest_EX_M,
  input  logic [AW-1:0]        dest_M_WB,
  input  logic                 wb_RF_EX,
  input  logic                 wb_EX_M,
  input  logic                 wb_M_WB,
  input  logic                 ld_RF_EX,
  input  logic                 ld_EX_M,
  input  logic                 mc_issue,
  input  logic [AW-1:0]        mc_dest,
  input  logic [LATW-1:0]      mc_lat,
  input  logic                 cnt_clr,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic                 stall,
  output logic [(1<<AW)-1:0]   busy_vec,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     stall_max
);

  localparam int NREG = 1 << AW;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [LATW-1:0]   sb_cnt [NREG];
  logic [CNT_W-1:0]  run_q;
  logic [CNT_W-1:0]  run_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic [NSRC*2-1:0] fwd_raw;
  logic              hazard;

  // A register is busy while its latency count is still running down.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (sb_cnt[r] != '0);
    end
  end

  // Per-source forwarding priority and hazard detection; loads in RF_EX and
  // EX_M cannot forward, so a match there is a load-use stall instead.
  always_comb begin
    fwd_raw = '0;
    hazard  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      logic [AW-1:0] s;
      logic          act;
      s   = src_ID_RF[i*AW +: AW];
      act = src_vld[i] && !((R0_ZERO != 0) && (s == '0));
      if (act) begin
        if (wb_RF_EX && (dest_RF_EX == s) && !ld_RF_EX)
          fwd_raw[i*2 +: 2] = 2'b01;
        else if (wb_EX_M && (dest_EX_M == s) && !ld_EX_M)
          fwd_raw[i*2 +: 2] = 2'b10;
        else if (wb_M_WB && (dest_M_WB == s))
          fwd_raw[i*2 +: 2] = 2'b11;
        if ((wb_RF_EX && ld_RF_EX && (dest_RF_EX == s)) ||
            (wb_EX_M  && ld_EX_M  && (dest_EX_M  == s)) ||
            busy_vec[s])
          hazard = 1'b1;
      end
    end
    stall   = hazard;
    fwd_sel = hazard ? '0 : fwd_raw;
  end

  // Scoreboard counters: an issue loads the latency (overwriting any running
  // count), every other nonzero count decrements once per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) sb_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (mc_issue && (mc_dest == AW'(r)) && !((R0_ZERO != 0) && (r == 0)))
          sb_cnt[r] <= mc_lat;
        else if (sb_cnt[r] != '0)
          sb_cnt[r] <= sb_cnt[r] - 1'b1;
      end
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Stall FSM next state: follow the combinational stall.
  always_comb begin
    state_d = state_q;
    if (stall) state_d = STALL;
    else       state_d = RUN;
  end

  // Saturating increments used by the statistics.
  always_comb begin
    run_inc = (run_q == '1) ? run_q : run_q + CNT_W'(1);
    cnt_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + CNT_W'(1);
  end

  // Statistics: total stalled cycles and the longest run, both saturating;
  // the running maximum already includes the current stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      stall_max <= '0;
      run_q     <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      stall_max <= '0;
      run_q     <= '0;
    end else if (stall) begin
      stall_cnt <= cnt_inc;
      run_q     <= run_inc;
      if (run_inc > stall_max) stall_max <= run_inc;
    end else begin
      if ((state_q == STALL) && (run_q > stall_max)) stall_max <= run_q;
      run_q <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors for hazard_forward_unit with
// AW=3, NSRC=2, LATW=3, CNT_W=4, R0_ZERO=1; expected responses are queued
// by the driver and compared by an independent negedge monitor.
module tb_hazard_forward_unit;

  localparam int AW = 3, NSRC = 2, LATW = 3, CNT_W = 4;

  // Packed expectation: {chk[4:0], fwd[3:0], stall, busy[7:0], cnt[3:0], mx[3:0]}
  // chk bits: 4=fwd 3=stall 2=busy 1=cnt 0=max
  localparam int EW = 26;
  localparam logic [4:0] C_ALL = 5'b11111;
  localparam logic [4:0] C_COMB = 5'b11000;
  localparam logic [4:0] C_SB = 5'b11100;
  localparam logic [4:0] C_STAT = 5'b01011;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC*AW-1:0] src_ID_RF;
  logic [NSRC-1:0]   src_vld;
  logic [AW-1:0]     dest_RF_EX, dest_EX_M, dest_M_WB;
  logic              wb_RF_EX, wb_EX_M, wb_M_WB, ld_RF_EX, ld_EX_M;
  logic              mc_issue;
  logic [AW-1:0]     mc_dest;
  logic [LATW-1:0]   mc_lat;
  logic              cnt_clr;
  logic [NSRC*2-1:0] fwd_sel;
  logic              stall;
  logic [7:0]        busy_vec;
  logic [CNT_W-1:0]  stall_cnt, stall_max;

  logic [EW-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  hazard_forward_unit #(
    .AW(AW), .NSRC(NSRC), .LATW(LATW), .CNT_W(CNT_W), .R0_ZERO(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_ID_RF(src_ID_RF), .src_vld(src_vld),
    .dest_RF_EX(dest_RF_EX), .dest_EX_M(dest_EX_M), .dest_M_WB(dest_M_WB),
    .wb_RF_EX(wb_RF_EX), .wb_EX_M(wb_EX_M), .wb_M_WB(wb_M_WB),
    .ld_RF_EX(ld_RF_EX), .ld_EX_M(ld_EX_M), .mc_issue(mc_issue),
    .mc_dest(mc_dest), .mc_lat(mc_lat), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_sel), .stall(stall), .busy_vec(busy_vec),
    .stall_cnt(stall_cnt), .stall_max(stall_max)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard compare helper
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Monitor: on every falling edge, compare everything queued this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      if (e[25]) check("fwd_sel",   {4'h0, fwd_sel},   {4'h0, e[20:17]});
      if (e[24]) check("stall",     {7'h0, stall},     {7'h0, e[16]});
      if (e[23]) check("busy_vec",  busy_vec,          e[15:8]);
      if (e[22]) check("stall_cnt", {4'h0, stall_cnt}, {4'h0, e[7:4]});
      if (e[21]) check("stall_max", {4'h0, stall_max}, {4'h0, e[3:0]});
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [4:0] chk, input logic [3:0] f, input logic s,
                            input logic [7:0] b, input logic [3:0] c, input logic [3:0] m);
    exp_q.push_back({chk, f, s, b, c, m});
  endtask

  task automatic idle_inputs();
    src_ID_RF = '0; src_vld = '0;
    dest_RF_EX = '0; dest_EX_M = '0; dest_M_WB = '0;
    wb_RF_EX = 0; wb_EX_M = 0; wb_M_WB = 0; ld_RF_EX = 0; ld_EX_M = 0;
    mc_issue = 0; mc_dest = '0; mc_lat = '0; cnt_clr = 0;
  endtask

  task automatic set_src(input logic [AW-1:0] s1, input logic [AW-1:0] s0, input logic [1:0] v);
    src_ID_RF = {s1, s0};
    src_vld   = v;
  endtask

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    cyc();
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    cyc();
    rst_n = 1'b1;

    // Forwarding priority: RF_EX beats EX_M
    cyc();
    set_src(3'd0, 3'd3, 2'b01);
    dest_RF_EX = 3'd3; wb_RF_EX = 1; dest_EX_M = 3'd3; wb_EX_M = 1;
    expect_out(C_COMB, 4'b0001, 1'b0, 8'h00, 4'd0, 4'd0);
    // RF_EX not writing -> EX_M
    cyc();
    wb_RF_EX = 0;
    expect_out(C_COMB, 4'b0010, 1'b0, 8'h00, 4'd0, 4'd0);
    // Both sources from M_WB
    cyc();
    set_src(3'd3, 3'd3, 2'b11);
    wb_EX_M = 0; dest_M_WB = 3'd3; wb_M_WB = 1;
    expect_out(C_COMB, 4'b1111, 1'b0, 8'h00, 4'd0, 4'd0);
    // Invalid sources never forward
    cyc();
    src_vld = 2'b00; wb_RF_EX = 1; wb_EX_M = 1;
    expect_out(C_COMB, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Load-use sequence: two stall cycles then M_WB forward
    cyc();
    idle_inputs();
    set_src(3'd5, 3'd0, 2'b10);
    dest_RF_EX = 3'd5; wb_RF_EX = 1; ld_RF_EX = 1;
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h00, 4'd0, 4'd0);
    cyc();
    dest_RF_EX = 3'd0; wb_RF_EX = 0; ld_RF_EX = 0;
    dest_EX_M = 3'd5; wb_EX_M = 1; ld_EX_M = 1;
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h00, 4'd1, 4'd1);
    cyc();
    dest_EX_M = 3'd0; wb_EX_M = 0; ld_EX_M = 0;
    dest_M_WB = 3'd5; wb_M_WB = 1;
    expect_out(C_ALL, 4'b1100, 1'b0, 8'h00, 4'd2, 4'd2);
    // Clear statistics
    cyc();
    idle_inputs();
    cnt_clr = 1;
    expect_out(C_STAT, 4'b0000, 1'b0, 8'h00, 4'd2, 4'd2);
    cyc();
    cnt_clr = 0;
    expect_out(C_STAT, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Multi-cycle issue to r4, lat 3; same-cycle check sees pre-edge busy
    cyc();
    set_src(3'd0, 3'd4, 2'b01);
    mc_issue = 1; mc_dest = 3'd4; mc_lat = 3'd3;
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    cyc();
    mc_issue = 0;
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h10, 4'd0, 4'd0);
    cyc();
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h10, 4'd1, 4'd1);
    cyc();
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h10, 4'd2, 4'd2);
    cyc();
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd3, 4'd3);

    // Zero latency leaves register idle
    cyc();
    idle_inputs();
    mc_issue = 1; mc_dest = 3'd6; mc_lat = 3'd0;
    cyc();
    mc_issue = 0;
    expect_out(C_SB, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    // Reissue to a busy register overwrites its count
    cyc();
    mc_issue = 1; mc_dest = 3'd1; mc_lat = 3'd7;
    cyc();
    mc_lat = 3'd1;
    expect_out(C_SB, 4'b0000, 1'b0, 8'h02, 4'd0, 4'd0);
    cyc();
    mc_issue = 0;
    expect_out(C_SB, 4'b0000, 1'b0, 8'h02, 4'd0, 4'd0);
    cyc();
    expect_out(C_SB, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Register 0 never stalls, forwards or goes busy
    cyc();
    set_src(3'd0, 3'd0, 2'b11);
    dest_RF_EX = 3'd0; wb_RF_EX = 1; ld_RF_EX = 1; dest_M_WB = 3'd0; wb_M_WB = 1;
    expect_out(C_COMB, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    cyc();
    idle_inputs();
    mc_issue = 1; mc_dest = 3'd0; mc_lat = 3'd5;
    cyc();
    mc_issue = 0;
    expect_out(C_SB, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Saturation: hold a load-use hazard for 20 cycles with 4-bit counters
    cyc();
    cnt_clr = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      cnt_clr = 0;
      set_src(3'd7, 3'd0, 2'b10);
      dest_RF_EX = 3'd7; wb_RF_EX = 1; ld_RF_EX = 1;
      expect_out(C_STAT, 4'b0000, 1'b1, 8'h00, 4'((k > 15) ? 15 : k), 4'((k > 15) ? 15 : k));
    end
    // Clear while the hazard is still present: clear wins
    cyc();
    cnt_clr = 1;
    expect_out(C_STAT, 4'b0000, 1'b1, 8'h00, 4'd15, 4'd15);
    cyc();
    cnt_clr = 0;
    idle_inputs();
    expect_out(C_STAT, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Reset mid-stall abandons the scoreboard entry
    cyc();
    mc_issue = 1; mc_dest = 3'd2; mc_lat = 3'd7;
    cyc();
    mc_issue = 0;
    set_src(3'd0, 3'd2, 2'b01);
    expect_out(C_ALL, 4'b0000, 1'b1, 8'h04, 4'd0, 4'd0);
    cyc();
    rst_n = 1'b0;
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    cyc();
    rst_n = 1'b1;
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);
    cyc();
    expect_out(C_ALL, 4'b0000, 1'b0, 8'h00, 4'd0, 4'd0);

    // Drain with a bounded wait
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
